// File: rtl/random_seq_pkg.sv
// Shared definitions for the pseudo-random sequence checker: FSM states and
// the ordered code table of the 4-bit sequence counter.
package random_seq_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

    localparam int SEQ_LEN = 8;

    // Code emitted at each sequence position, position 0 first.
    localparam logic [3:0] SEQ_CODES [SEQ_LEN] = '{
        4'b0000, 4'b1101, 4'b1011, 4'b1001,
        4'b0110, 4'b1100, 4'b0011, 4'b1111
    };

endpackage

// File: rtl/random_seq_decode.sv
// Combinational decode of a received 4-bit code to its sequence position,
// with a flag for codes that never appear in the sequence.
module random_seq_decode
    import random_seq_pkg::*;
(
    input  logic [3:0] code,
    output logic [2:0] pos,
    output logic       legal
);

    always_comb begin
        pos   = '0;
        legal = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (code == SEQ_CODES[i]) begin
                pos   = 3'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_seq_checker.sv
// Receive-side integrity monitor for the 4-bit pseudo-random sequence stream.
// Define RANDOM_SEQ_CHECKER_ERR_CNT_EN to build the saturating err_count.
module random_seq_checker
    import random_seq_pkg::*;
#(
    parameter int LOCK_LEN = 3,
    parameter int MISS_MAX = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [3:0]       d,
    input  logic             d_valid,
    output logic [2:0]       idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] LOCK_N = 3'(LOCK_LEN);
    localparam logic [2:0] MISS_N = 3'(MISS_MAX);

    seq_state_t state_q, state_n;
    logic [2:0] exp_q, exp_n;
    logic [2:0] run_q, run_n;
    logic [2:0] miss_q, miss_n;
    logic       err_n;

    logic [2:0] pos;
    logic       legal;
    logic       match;

    random_seq_decode u_decode (
        .code  (d),
        .pos   (pos),
        .legal (legal)
    );

    assign match = legal && (pos == exp_q);

    always_comb begin
        state_n = state_q;
        exp_n   = exp_q;
        run_n   = run_q;
        miss_n  = miss_q;
        err_n   = 1'b0;
        if (d_valid) begin
            case (state_q)
                HUNT: begin
                    if (legal) begin
                        exp_n   = pos + 3'd1;
                        run_n   = 3'd1;
                        state_n = (LOCK_N == 3'd1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (!legal) begin
                        state_n = HUNT;
                    end else if (match) begin
                        run_n = run_q + 3'd1;
                        exp_n = pos + 3'd1;
                        if (run_q + 3'd1 == LOCK_N)
                            state_n = LOCKED;
                    end else begin
                        run_n = 3'd1;
                        exp_n = pos + 3'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expected position advances even on a miss,
                    // so a single corrupted sample does not cost resync.
                    exp_n = exp_q + 3'd1;
                    if (match) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (miss_q + 3'd1 == MISS_N) begin
                            state_n = HUNT;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_q + 3'd1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            run_q     <= '0;
            miss_q    <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_n;
            exp_q     <= exp_n;
            run_q     <= run_n;
            miss_q    <= miss_n;
            idx_valid <= d_valid && legal;
            err       <= err_n;
            if (d_valid && legal)
                idx <= pos;
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef RANDOM_SEQ_CHECKER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!clear)
            err_count <= '0;
        else if (err_n && (err_count != '1))
            err_count <= err_count + 1'b1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_random_seq_checker.sv
// Scoreboard bench for random_seq_checker: directed scenarios then random
// traffic, checked against a history-based model of lock acquisition.
module tb_random_seq_checker;

    localparam int LOCK_LEN = 3;
    localparam int MISS_MAX = 2;
    localparam int CNT_W    = 8;
    localparam int CMAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic [2:0] idx;
        logic       iv;
        logic       lk;
        logic       er;
        int         cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic [3:0]       d = '0;
    logic             d_valid = 1'b0;
    logic [2:0]       idx;
    logic             idx_valid;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;

    random_seq_checker #(
        .LOCK_LEN (LOCK_LEN),
        .MISS_MAX (MISS_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .d         (d),
        .d_valid   (d_valid),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [3:0] codes [8] = '{4'h0, 4'hD, 4'hB, 4'h9, 4'h6, 4'hC, 4'h3, 4'hF};

    // Reference model: outside lock, a history of consecutive legal
    // successor positions; lock once it holds LOCK_LEN entries.
    int  m_hist[$];
    bit  m_locked = 0;
    int  m_exp = 0;
    int  m_miss = 0;
    int  m_cnt = 0;
    int  m_idx = 0;

    function automatic int dec(input logic [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b1001: return 3;
            4'b0110: return 4;
            4'b1100: return 5;
            4'b0011: return 6;
            4'b1111: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic step(input logic c, input logic v, input logic [3:0] code);
        exp_t e;
        int   p;
        @(negedge clk);
        clear   = c;
        d_valid = v;
        d       = code;
        e.iv = 1'b0;
        e.er = 1'b0;
        if (!c) begin
            m_hist.delete();
            m_locked = 0; m_exp = 0; m_miss = 0; m_cnt = 0; m_idx = 0;
        end else if (v) begin
            p = dec(code);
            if (p >= 0) begin
                e.iv  = 1'b1;
                m_idx = p;
            end
            if (m_locked) begin
                if (p != m_exp) begin
                    e.er = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_miss++;
                    if (m_miss == MISS_MAX) begin
                        m_locked = 0;
                        m_miss   = 0;
                        m_hist.delete();
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = (m_exp + 1) % 8;
            end else begin
                if (p < 0)
                    m_hist.delete();
                else if (m_hist.size() > 0 && p == (m_hist[$] + 1) % 8)
                    m_hist.push_back(p);
                else
                    m_hist = '{p};
                if (m_hist.size() == LOCK_LEN) begin
                    m_locked = 1;
                    m_exp    = (p + 1) % 8;
                    m_hist.delete();
                end
            end
        end
        e.idx = 3'(m_idx);
        e.lk  = m_locked;
`ifdef RANDOM_SEQ_CHECKER_ERR_CNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic send(input int p);
        step(1'b1, 1'b1, codes[p % 8]);
    endtask

    // Monitor: the DUT presents a fresh output state every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (idx !== e.idx || idx_valid !== e.iv || locked !== e.lk ||
                err !== e.er || err_count !== CNT_W'(e.cnt)) begin
                errors++;
                $display("FAIL outputs t=%0t got idx=%0d iv=%0b lk=%0b err=%0b cnt=%0d want idx=%0d iv=%0b lk=%0b err=%0b cnt=%0d",
                         $time, idx, idx_valid, locked, err, err_count,
                         e.idx, e.iv, e.lk, e.er, e.cnt);
            end
        end
    end

    initial begin
        int sp;
        int r;
        int w;

        // Reset, lock and decode
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hD);
        for (int i = 0; i < 4; i++) send(i);
        // Wrap while locked
        for (int i = 4; i < 10; i++) send(i);
        // Single slip: 1100 twice after 1001
        send(2); send(3); send(5); send(5); send(6); send(7);
        // Loss through two illegal codes, then reacquire
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h1);
        send(0); send(1); send(2);
        // Gap of 5 idle cycles mid-sequence
        send(3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom));
        send(4); send(5);
        // Clear while locked with a nonzero error count
        step(1'b0, 1'b1, codes[6]);
        step(1'b1, 1'b0, 4'h0);

        // Drive the error counter into saturation
        for (int k = 0; k < 140; k++) begin
            send(0); send(1); send(2);
            step(1'b1, 1'b1, 4'h1);
            step(1'b1, 1'b1, 4'hE);
        end
        send(0); send(1); send(2); send(7); send(7);

        // Random traffic: mostly in-order codes with slips, junk and gaps
        sp = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                send(sp); sp = (sp + 1) % 8;
            end else if (r < 80) begin
                step(1'b1, 1'b1, 4'($urandom));
            end else if (r < 90) begin
                step(1'b1, 1'b0, 4'($urandom));
            end else if (r < 98) begin
                sp = (sp + $urandom_range(1, 7)) % 8;
                send(sp); sp = (sp + 1) % 8;
            end else begin
                step(1'b0, 1'($urandom), 4'($urandom));
            end
        end

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
